// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared definitions for the PWM generator slice.
//   PWM_WIDTH_DEF : default counter/duty/period width in bits
//   PWM_DEAD_DEF  : default dead-time in clk_in cycles
//   dt_state_t    : dead-time FSM state encoding (used when PWM_DEADTIME_EN is defined)
package pwm_pkg;

    localparam int unsigned PWM_WIDTH_DEF = 8;
    localparam int unsigned PWM_DEAD_DEF  = 2;

    typedef enum logic [1:0] {
        LOW_OFF = 2'd0,
        DEAD_LH = 2'd1,
        HIGH_ON = 2'd2,
        DEAD_HL = 2'd3
    } dt_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime -- inserts DEAD cycles of both-off between complementary
// outputs on every edge of the raw PWM signal.
// Ports:
//   clk_in : clock, rising edge
//   rst    : synchronous active-high reset (state LOW_OFF, outputs 0)
//   en     : run enable; the low side is held off while the block is idle
//   raw    : registered raw PWM level from the counter/compare stage
//   pwm_h  : high-side output
//   pwm_l  : low-side output
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int unsigned DEAD = PWM_DEAD_DEF
) (
    input  logic clk_in,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic pwm_h,
    output logic pwm_l
);

    localparam logic [3:0] DLAST = 4'(DEAD - 1);

    dt_state_t  state, state_nxt;
    logic [3:0] dcnt, dcnt_nxt;
    logic       act;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= LOW_OFF;
            dcnt  <= '0;
            act   <= 1'b0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            act   <= en;
        end
    end

    // A raw edge seen inside a dead interval restarts the interval toward
    // the new level, so a pulse shorter than DEAD never reaches an output.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        unique case (state)
            LOW_OFF: begin
                if (raw) begin
                    state_nxt = DEAD_LH;
                    dcnt_nxt  = '0;
                end
            end
            DEAD_LH: begin
                if (!raw) begin
                    state_nxt = DEAD_HL;
                    dcnt_nxt  = '0;
                end else if (dcnt == DLAST) begin
                    state_nxt = HIGH_ON;
                end else begin
                    dcnt_nxt = dcnt + 4'd1;
                end
            end
            HIGH_ON: begin
                if (!raw) begin
                    state_nxt = DEAD_HL;
                    dcnt_nxt  = '0;
                end
            end
            DEAD_HL: begin
                if (raw) begin
                    state_nxt = DEAD_LH;
                    dcnt_nxt  = '0;
                end else if (dcnt == DLAST) begin
                    state_nxt = LOW_OFF;
                end else begin
                    dcnt_nxt = dcnt + 4'd1;
                end
            end
            default: begin
                state_nxt = LOW_OFF;
                dcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        pwm_h = (state == HIGH_ON);
        pwm_l = (state == LOW_OFF) && act;
    end

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen -- period/duty PWM generator with a one-deep configuration buffer
// that is applied on period boundaries (or immediately while disabled).
// Optional feature: define PWM_DEADTIME_EN to route the outputs through
// the pwm_deadtime FSM; otherwise pwm_l is the registered complement.
// Ports:
//   clk_in       : clock, rising edge
//   rst          : synchronous active-high reset
//   tick         : one-cycle count enable from the clock divider
//   en           : run enable
//   cfg_valid    : a new period/duty pair is offered
//   cfg_ready    : no pair pending, a new one can be accepted
//   cfg_period   : terminal count (period is cfg_period+1 ticks)
//   cfg_duty     : high ticks per period
//   pwm_h        : high-side output
//   pwm_l        : low-side output
//   period_start : one-cycle pulse after each wrap and after en rises
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH_DEF,
    parameter int unsigned DEAD  = PWM_DEAD_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             period_start
);

    if (DEAD < 1 || DEAD > 15) begin : g_dead_range
        $error("pwm_gen: DEAD must be in 1..15");
    end

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] period_act;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] pend_period;
    logic [WIDTH-1:0] pend_duty;
    logic             pend_valid;
    logic             en_d;
    logic             raw;
    logic             wrap;
    logic             cap;
    logic             below_duty;

    assign cfg_ready  = ~pend_valid;
    assign wrap       = tick && en && (cnt == period_act);
    assign cap        = cfg_valid && cfg_ready;
    assign below_duty = (cnt < duty_act);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt          <= '0;
            period_act   <= '1;
            duty_act     <= '0;
            pend_period  <= '0;
            pend_duty    <= '0;
            pend_valid   <= 1'b0;
            en_d         <= 1'b0;
            raw          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (!en) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= (cnt == period_act) ? '0 : cnt + 1'b1;
            end

            // Only an already-pending pair is applied, so a capture that
            // coincides with a wrap waits for the following wrap.
            if (pend_valid && (!en || wrap)) begin
                period_act <= pend_period;
                duty_act   <= pend_duty;
                pend_valid <= 1'b0;
            end else if (cap) begin
                pend_period <= cfg_period;
                pend_duty   <= cfg_duty;
                pend_valid  <= 1'b1;
            end

            en_d         <= en;
            raw          <= en && below_duty;
            period_start <= wrap || (en && !en_d);
        end
    end

`ifdef PWM_DEADTIME_EN
    pwm_deadtime #(
        .DEAD(DEAD)
    ) u_deadtime (
        .clk_in(clk_in),
        .rst   (rst),
        .en    (en),
        .raw   (raw),
        .pwm_h (pwm_h),
        .pwm_l (pwm_l)
    );
`else
    logic raw_l;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            raw_l <= 1'b0;
        end else begin
            raw_l <= en && !below_duty;
        end
    end

    // Gated with en so both sides are off for the whole idle interval,
    // including the cycle before the registered levels catch up.
    assign pwm_h = raw && en;
    assign pwm_l = raw_l && en;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen -- directed, table-driven bench for pwm_gen (WIDTH=8, DEAD=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. each table row holds the inputs seen by one edge and the
// outputs expected just after it.
module tb_pwm_gen;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_period = '0;
    logic [7:0] cfg_duty = '0;
    logic       pwm_h;
    logic       pwm_l;
    logic       period_start;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk_in = ~clk_in;

    pwm_gen #(
        .WIDTH(8),
        .DEAD (2)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .tick        (tick),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .pwm_h       (pwm_h),
        .pwm_l       (pwm_l),
        .period_start(period_start)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       tick;
        logic       cv;
        logic [7:0] per;
        logic [7:0] duty;
        logic       eh;
        logic       el;
        logic       eps;
        logic       erdy;
        logic       chk_hl;
    } vec_t;

    localparam int NV = 110;
    vec_t vt[NV];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eh, input logic el,
                           input logic eps, input logic erdy);
        chk({tag, ".pwm_h"}, pwm_h, eh);
        chk({tag, ".pwm_l"}, pwm_l, el);
        chk({tag, ".period_start"}, period_start, eps);
        chk({tag, ".cfg_ready"}, cfg_ready, erdy);
    endtask

    initial begin
        // Duty in force for each 10-cycle period of the table run:
        // 3 initially, 5 loaded mid-period 3, 1 offered on the wrap of
        // period 5 (in force one period later), then 0 and 10.
        int duty_of_p[11] = '{3, 3, 3, 3, 5, 5, 5, 1, 1, 0, 10};

        for (int k = 0; k < NV; k++) begin
            int p;
            int c;
            p = k / 10;
            c = k % 10;
            vt[k].rst    = 1'b0;
            vt[k].en     = 1'b1;
            vt[k].tick   = 1'b1;
            vt[k].cv     = 1'b0;
            vt[k].per    = 8'd9;
            vt[k].duty   = 8'd0;
            vt[k].eh     = (c < duty_of_p[p]);
            vt[k].el     = !(c < duty_of_p[p]);
            vt[k].chk_hl = 1'b1;
`ifdef PWM_DEADTIME_EN
            // Only the duty=5 period and the 1-tick pulse period are checked
            // against hand-derived dead-time waveforms.
            vt[k].chk_hl = (p == 4) || (p == 7);
            if (p == 4) begin
                vt[k].eh = (c >= 3) && (c <= 5);
                vt[k].el = (c == 0) || (c >= 8);
            end else if (p == 7) begin
                vt[k].eh = 1'b0;
                vt[k].el = (c == 0) || (c >= 4);
            end
`endif
            vt[k].eps  = (k == 0) || (c == 9);
            vt[k].erdy = !((k >= 34 && k <= 38) || (k >= 59 && k <= 68) ||
                           (k >= 80 && k <= 88) || (k >= 90 && k <= 98));
        end
        // Mid-period load of duty 5, then held valid with other data while
        // not ready: that data must not be taken.
        for (int k = 34; k <= 37; k++) begin
            vt[k].cv   = 1'b1;
            vt[k].duty = (k == 34) ? 8'd5 : 8'd1;
        end
        // Offer coinciding with the wrap.
        vt[59].cv   = 1'b1;
        vt[59].duty = 8'd1;
        vt[80].cv   = 1'b1;
        vt[80].duty = 8'd0;
        vt[90].cv   = 1'b1;
        vt[90].duty = 8'd10;

        // Reset state.
        rst  = 1'b1;
        en   = 1'b0;
        tick = 1'b1;
        step();
        step();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b1);

        // Load while idle: captured, then applied on the next cycle.
        rst        = 1'b0;
        cfg_valid  = 1'b1;
        cfg_period = 8'd9;
        cfg_duty   = 8'd3;
        step();
        chk("idle_capture.cfg_ready", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        step();
        chk_all("idle_apply", 1'b0, 1'b0, 1'b0, 1'b1);
        // tick without en must not move the counter (table assumes cnt=0).
        step();
        chk_all("idle_tick", 1'b0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < NV; k++) begin
            rst        = vt[k].rst;
            en         = vt[k].en;
            tick       = vt[k].tick;
            cfg_valid  = vt[k].cv;
            cfg_period = vt[k].per;
            cfg_duty   = vt[k].duty;
            step();
            if (vt[k].chk_hl) begin
                chk($sformatf("v%0d.pwm_h", k), pwm_h, vt[k].eh);
                chk($sformatf("v%0d.pwm_l", k), pwm_l, vt[k].el);
            end
            chk($sformatf("v%0d.period_start", k), period_start, vt[k].eps);
            chk($sformatf("v%0d.cfg_ready", k), cfg_ready, vt[k].erdy);
        end

        // Reset at cnt=4 with a pair (duty 5) pending.
        cfg_valid  = 1'b1;
        cfg_period = 8'd9;
        cfg_duty   = 8'd5;
        step();
        chk("rst_pend.cfg_ready", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rst_pre.pwm_h", pwm_h, 1'b1);
        rst = 1'b1;
        step();
        chk_all("rst_mid", 1'b0, 1'b0, 1'b0, 1'b1);
        // While idle a surviving pending pair would be applied at once.
        rst = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_all($sformatf("rst_idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        en = 1'b1;
        step();
        chk_all("rst_enable", 1'b0, 1'b1, 1'b1, 1'b1);
        // Reset values: duty 0, period 255, so no wrap and no high output.
        for (int i = 0; i < 10; i++) begin
            step();
            chk_all($sformatf("rst_run%0d", i), 1'b0, 1'b1, 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
